// File: rtl/spi_flash_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_engine
// Description : SPI-NOR (W25Q-style) command sequencer. Turns one word-level
//               read or write request into complete SPI transactions and
//               returns a 32-bit result with a ready flag.
//                 read  : 03 + addr24 + 32 data bits in (little-endian word)
//                 write : 06 | 02 + addr24 + 32 data bits out | 05/status
//                         polled with CS held low until WIP clears
// Option      : FLASH_ERASE_EN - when defined, a write whose word address has
//               bits [11:0] = 0 is preceded by 06 | 20 + addr24 | status poll
//               (sector erase). When undefined, 0x20 is never issued.
// Ports       : clk, reset (async, active low)
//               flash_enable/read_enable/write_enable  request levels
//               read_address, write_address, data_to_write  request operands
//               flash_miso / flash_clk / flash_mosi / flash_cs  SPI mode 0
//               ready (1 = idle), data_out (last read word or error code)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_engine #(
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 4,
    parameter int POLL_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flash_enable,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [23:0] read_address,
    input  logic [23:0] write_address,
    input  logic [31:0] data_to_write,
    input  logic        flash_miso,
    output logic        flash_clk,
    output logic        flash_mosi,
    output logic        flash_cs,
    output logic        ready,
    output logic [31:0] data_out
);

    localparam logic [7:0]  c_div_reload = 8'(CLK_DIV - 1);
    localparam logic [15:0] c_gap_reload = (CS_GAP > 0) ? 16'(CS_GAP - 1) : 16'd0;
    localparam int          c_pcw        = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);
    localparam logic [c_pcw-1:0] c_poll_limit = c_pcw'(POLL_LIMIT);

    localparam logic [7:0]  c_op_read  = 8'h03;
    localparam logic [7:0]  c_op_prog  = 8'h02;
    localparam logic [7:0]  c_op_wren  = 8'h06;
    localparam logic [7:0]  c_op_rdsr  = 8'h05;
    localparam logic [7:0]  c_op_erase = 8'h20;
    localparam logic [31:0] c_err_prog  = 32'hDEAD_0001;
    localparam logic [31:0] c_err_erase = 32'hDEAD_0002;

    typedef enum logic [2:0] {
        IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, DATA = 3'd3,
        GAP  = 3'd4, WREN = 3'd5, POLL = 3'd6, DONE = 3'd7
    } state_t;

    // One CS-low frame of the overall operation; decides what follows GAP.
    typedef enum logic [2:0] {
        FR_READ = 3'd0, FR_WREN_E = 3'd1, FR_ERASE = 3'd2, FR_POLL_E = 3'd3,
        FR_WREN = 3'd4, FR_PROG   = 3'd5, FR_POLL  = 3'd6
    } frame_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0, ERR_PROG = 2'd1, ERR_ERASE = 2'd2
    } err_t;

    state_t           state_q;
    frame_t           frame_q;
    err_t             err_q;
    logic             cs_q, sck_q, mosi_q, ready_q, go_q;
    logic [31:0]      data_out_q;
    logic [7:0]       div_q;
    logic [15:0]      gap_q;
    logic [5:0]       bitcnt_q;      // bits left in segment; 0 = trailing CS hold
    logic [31:0]      sh_out_q;
    logic [31:0]      sh_in_q;
    logic [23:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [c_pcw-1:0] poll_cnt_q;

    logic             go_d, launch_d, gap_done_d, poll_wip_d;
    frame_t           launch_frame_d, gap_frame_d, start_frame_d;
    state_t           start_state_d;
    logic [5:0]       start_bits_d;
    logic [31:0]      start_shift_d;
    logic [c_pcw-1:0] poll_cnt_d;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign go_d       = flash_enable & (read_enable | write_enable);
    assign launch_d   = go_d & ~go_q;
    assign poll_cnt_d = poll_cnt_q + c_pcw'(1);
    // Status byte is shifted in MSB first, so WIP is the last bit received.
    assign poll_wip_d = sh_in_q[0];

    // Write wins when both request levels are present at the launch edge.
    always_comb begin
        launch_frame_d = FR_READ;
        if (write_enable) begin
`ifdef FLASH_ERASE_EN
            launch_frame_d = (write_address[11:2] == 10'd0) ? FR_WREN_E : FR_WREN;
`else
            launch_frame_d = FR_WREN;
`endif
        end
    end

    always_comb begin
        gap_frame_d = FR_READ;
        gap_done_d  = 1'b1;
        case (frame_q)
            FR_WREN_E: begin gap_frame_d = FR_ERASE;  gap_done_d = 1'b0; end
            FR_ERASE:  begin gap_frame_d = FR_POLL_E; gap_done_d = 1'b0; end
            FR_POLL_E: begin gap_frame_d = FR_WREN;   gap_done_d = (err_q != ERR_NONE); end
            FR_WREN:   begin gap_frame_d = FR_PROG;   gap_done_d = 1'b0; end
            FR_PROG:   begin gap_frame_d = FR_POLL;   gap_done_d = 1'b0; end
            default:   ;
        endcase
    end

    assign start_frame_d = (state_q == IDLE) ? launch_frame_d : gap_frame_d;

    // First segment of whichever frame is about to start.
    always_comb begin
        start_state_d = CMD;
        start_bits_d  = 6'd8;
        start_shift_d = {c_op_read, 24'h0};
        case (start_frame_d)
            FR_WREN_E, FR_WREN: begin
                start_state_d = WREN;
                start_shift_d = {c_op_wren, 24'h0};
            end
            FR_ERASE: start_shift_d = {c_op_erase, 24'h0};
            FR_PROG:  start_shift_d = {c_op_prog, 24'h0};
            FR_POLL_E, FR_POLL: begin
                start_state_d = POLL;
                start_bits_d  = 6'd16;
                start_shift_d = {c_op_rdsr, 24'h0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            frame_q    <= FR_READ;
            err_q      <= ERR_NONE;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            go_q       <= 1'b0;
            data_out_q <= 32'h0;
            div_q      <= 8'h0;
            gap_q      <= 16'h0;
            bitcnt_q   <= 6'h0;
            sh_out_q   <= 32'h0;
            sh_in_q    <= 32'h0;
            addr_q     <= 24'h0;
            wdata_q    <= 32'h0;
            poll_cnt_q <= '0;
        end else begin
            go_q <= go_d;
            case (state_q)
                IDLE: begin
                    if (launch_d) begin
                        ready_q <= 1'b0;
                        err_q   <= ERR_NONE;
                        wdata_q <= data_to_write;
                        addr_q  <= (write_enable ? write_address : read_address) & 24'hFF_FFFC;
                        frame_q    <= start_frame_d;
                        state_q    <= start_state_d;
                        cs_q       <= 1'b0;
                        sck_q      <= 1'b0;
                        div_q      <= c_div_reload;
                        bitcnt_q   <= start_bits_d;
                        sh_out_q   <= start_shift_d;
                        mosi_q     <= start_shift_d[31];
                        poll_cnt_q <= '0;
                    end
                end

                CMD, ADDR, DATA, WREN, POLL: begin
                    if (div_q != 8'd0) begin
                        div_q <= div_q - 8'd1;
                    end else begin
                        div_q <= c_div_reload;
                        if (!sck_q) begin
                            if (bitcnt_q == 6'd0) begin
                                // Trailing half-period done: end of frame.
                                cs_q    <= 1'b1;
                                state_q <= GAP;
                                gap_q   <= c_gap_reload;
                            end else begin
                                sck_q   <= 1'b1;
                                sh_in_q <= {sh_in_q[30:0], flash_miso};
                            end
                        end else begin
                            sck_q <= 1'b0;
                            if (bitcnt_q != 6'd1) begin
                                bitcnt_q <= bitcnt_q - 6'd1;
                                sh_out_q <= {sh_out_q[30:0], 1'b0};
                                mosi_q   <= sh_out_q[30];
                            end else if (state_q == CMD) begin
                                state_q  <= ADDR;
                                bitcnt_q <= 6'd24;
                                sh_out_q <= {addr_q, 8'h00};
                                mosi_q   <= addr_q[23];
                            end else if (state_q == ADDR && frame_q != FR_ERASE) begin
                                state_q  <= DATA;
                                bitcnt_q <= 6'd32;
                                if (frame_q == FR_PROG) begin
                                    sh_out_q <= bswap(wdata_q);
                                    mosi_q   <= wdata_q[7];
                                end else begin
                                    sh_out_q <= 32'h0;
                                    mosi_q   <= 1'b0;
                                end
                            end else if (state_q == POLL && poll_wip_d &&
                                         (poll_cnt_d < c_poll_limit)) begin
                                // Still busy: reissue 0x05 without releasing CS.
                                bitcnt_q   <= 6'd16;
                                sh_out_q   <= {c_op_rdsr, 24'h0};
                                mosi_q     <= c_op_rdsr[7];
                                poll_cnt_q <= poll_cnt_d;
                            end else begin
                                bitcnt_q <= 6'd0;
                                mosi_q   <= 1'b0;
                                if (state_q == POLL && poll_wip_d) begin
                                    err_q <= (frame_q == FR_POLL_E) ? ERR_ERASE : ERR_PROG;
                                end
                            end
                        end
                    end
                end

                GAP: begin
                    if (gap_q != 16'd0) begin
                        gap_q <= gap_q - 16'd1;
                    end else if (gap_done_d) begin
                        state_q <= DONE;
                    end else begin
                        frame_q    <= start_frame_d;
                        state_q    <= start_state_d;
                        cs_q       <= 1'b0;
                        sck_q      <= 1'b0;
                        div_q      <= c_div_reload;
                        bitcnt_q   <= start_bits_d;
                        sh_out_q   <= start_shift_d;
                        mosi_q     <= start_shift_d[31];
                        poll_cnt_q <= '0;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    if (frame_q == FR_READ) begin
                        // First byte received sits in [31:24]; word is little-endian.
                        data_out_q <= bswap(sh_in_q);
                    end else if (err_q == ERR_PROG) begin
                        data_out_q <= c_err_prog;
                    end else if (err_q == ERR_ERASE) begin
                        data_out_q <= c_err_erase;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign flash_cs   = cs_q;
    assign flash_clk  = sck_q;
    assign flash_mosi = mosi_q;
    assign ready      = ready_q;
    assign data_out   = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_engine
// Description : Self-checking bench for spi_flash_engine with a behavioural
//               SPI-NOR flash model and a scoreboard of expected MOSI bytes
//               and data_out words. FLASH_ERASE_EN selects erase expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_engine;

    localparam int CLK_DIV    = 2;
    localparam int CS_GAP     = 4;
    localparam int POLL_LIMIT = 5;
    localparam int RD_LAT     = 64*2*CLK_DIV + 2*CLK_DIV + CS_GAP + 2;

    logic        clk;
    logic        reset;
    logic        flash_enable, read_enable, write_enable;
    logic [23:0] read_address, write_address;
    logic [31:0] data_to_write;
    logic        flash_miso, flash_clk, flash_mosi, flash_cs, ready;
    logic [31:0] data_out;

    spi_flash_engine #(
        .CLK_DIV    (CLK_DIV),
        .CS_GAP     (CS_GAP),
        .POLL_LIMIT (POLL_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flash_enable  (flash_enable),
        .read_enable   (read_enable),
        .write_enable  (write_enable),
        .read_address  (read_address),
        .write_address (write_address),
        .data_to_write (data_to_write),
        .flash_miso    (flash_miso),
        .flash_clk     (flash_clk),
        .flash_mosi    (flash_mosi),
        .flash_cs      (flash_cs),
        .ready         (ready),
        .data_out      (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- flash model ----------------
    logic [7:0]  mem [0:1023];
    logic [7:0]  got_bytes [$];
    logic [7:0]  m_cur, m_cmd, m_out;
    logic [23:0] m_addr;
    logic [2:0]  m_bit;
    int          m_nbits, m_bi;
    int          m_status_cnt = 0;
    int          wip_until = 0;
    int          cs_falls = 0;
    int          ready_rises = 0;

    assign m_bit      = 3'(7 - (m_nbits % 8));
    assign flash_miso = m_out[m_bit];

    always @(negedge flash_cs or posedge flash_clk) begin
        if (!flash_clk) begin
            m_nbits = 0;
            m_out   = 8'h00;
            cs_falls++;
        end else if (!flash_cs) begin
            m_cur = {m_cur[6:0], flash_mosi};
            m_nbits++;
            if (m_nbits % 8 == 0) begin
                m_bi = m_nbits / 8;
                got_bytes.push_back(m_cur);
                if (m_bi == 1) m_cmd = m_cur;
                if (m_bi >= 2 && m_bi <= 4) m_addr = {m_addr[15:0], m_cur};
                m_out = 8'h00;
                if (m_cmd == 8'h03 && m_bi >= 4)
                    m_out = mem[m_addr[9:0] + 10'(m_bi - 4)];
                if (m_cmd == 8'h05) begin
                    if (m_bi % 2 == 1) m_out = {7'd0, (m_status_cnt < wip_until)};
                    else m_status_cnt++;
                end
            end
        end
    end

    always @(posedge ready) ready_rises++;

    // ---------------- scoreboard / checking ----------------
    logic [7:0]  exp_bytes [$];
    logic [31:0] exp_data [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic push_b(input logic [7:0] b);
        exp_bytes.push_back(b);
    endtask

    task automatic push_addr(input logic [23:0] a);
        logic [23:0] f;
        f = a & 24'hFF_FFFC;
        push_b(f[23:16]); push_b(f[15:8]); push_b(f[7:0]);
    endtask

    task automatic push_le(input logic [31:0] d);
        push_b(d[7:0]); push_b(d[15:8]); push_b(d[23:16]); push_b(d[31:24]);
    endtask

    task automatic push_polls(input int n);
        for (int i = 0; i < n; i++) begin push_b(8'h05); push_b(8'h00); end
    endtask

    task automatic push_read(input logic [23:0] a);
        push_b(8'h03); push_addr(a); push_le(32'h0);
    endtask

    task automatic push_prog(input logic [23:0] a, input logic [31:0] d, input int polls);
        push_b(8'h06); push_b(8'h02); push_addr(a); push_le(d); push_polls(polls);
    endtask

    task automatic compare_bytes(input int base);
        int n;
        n = exp_bytes.size();
        check_eq("mosi_count", 32'(got_bytes.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got_bytes.size())
                check_eq($sformatf("mosi_byte%0d", i), 32'(got_bytes[base + i]), 32'(exp_bytes[i]));
            else
                check_eq($sformatf("mosi_byte%0d", i), 32'hFFFF_FFFF, 32'(exp_bytes[i]));
        end
        exp_bytes.delete();
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [23:0] a,
                          input logic [31:0] d, input int wip, output int lat);
        int base, rises0, n;
        base   = got_bytes.size();
        rises0 = ready_rises;
        wip_until     = m_status_cnt + wip;
        read_address  = a;
        write_address = a;
        data_to_write = d;
        flash_enable  = 1'b1;
        read_enable   = rd;
        write_enable  = wr;
        @(negedge clk);
        check_eq("ready_fall", 32'(ready), 32'd0);
        // Operands must be captured at launch; scramble them afterwards.
        read_address  = ~a;
        write_address = ~a;
        data_to_write = ~d;
        n = 1;
        while (!ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("op_complete", 32'(ready), 32'd1);
        lat = n;
        flash_enable = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        check_eq("data_out", data_out, exp_data.pop_front());
        compare_bytes(base);
        repeat (3) @(negedge clk);
        check_eq("ready_rises", 32'(ready_rises - rises0), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, f0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
        mem[10'h104] = 8'h55; mem[10'h105] = 8'h66; mem[10'h106] = 8'h77; mem[10'h107] = 8'h88;

        reset = 1'b0;
        flash_enable = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
        read_address = 24'h0; write_address = 24'h0; data_to_write = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_cs",    32'(flash_cs),   32'd1);
        check_eq("rst_sck",   32'(flash_clk),  32'd0);
        check_eq("rst_mosi",  32'(flash_mosi), 32'd0);
        check_eq("rst_ready", 32'(ready),      32'd1);
        check_eq("rst_data",  data_out,        32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Read, unaligned address forced to word boundary.
        push_read(24'h000103);
        exp_data.push_back(32'h4433_2211);
        run_op(1'b1, 1'b0, 24'h000103, 32'h0, 0, lat);
        check_eq("read_latency_in_range", 32'(lat >= RD_LAT - 2 && lat <= RD_LAT + 2), 32'd1);

        // Write with three busy status reads; data_out unchanged.
        push_prog(24'h000204, 32'hA5B6_C7D8, 4);
        exp_data.push_back(32'h4433_2211);
        run_op(1'b0, 1'b1, 24'h000204, 32'hA5B6_C7D8, 3, lat);

        // Held request launches exactly once.
        f0 = cs_falls;
        read_address = 24'h000104; flash_enable = 1'b1; read_enable = 1'b1;
        repeat (2000) @(negedge clk);
        check_eq("hold_frames", 32'(cs_falls - f0), 32'd1);
        check_eq("hold_ready",  32'(ready), 32'd1);
        check_eq("hold_data",   data_out, 32'h8877_6655);
        read_enable = 1'b0; flash_enable = 1'b0;
        repeat (2) @(negedge clk);
        push_read(24'h000100);
        exp_data.push_back(32'h4433_2211);
        run_op(1'b1, 1'b0, 24'h000100, 32'h0, 0, lat);

        // Read and write together: write wins.
        push_prog(24'h000300, 32'h0102_0304, 1);
        exp_data.push_back(32'h4433_2211);
        run_op(1'b1, 1'b1, 24'h000300, 32'h0102_0304, 0, lat);

        // Program poll timeout after POLL_LIMIT busy status bytes.
        push_prog(24'h000208, 32'hCAFE_F00D, POLL_LIMIT);
        exp_data.push_back(32'hDEAD_0001);
        run_op(1'b0, 1'b1, 24'h000208, 32'hCAFE_F00D, 100, lat);

        // Reset during the address phase of a read.
        read_address = 24'h000104; flash_enable = 1'b1; read_enable = 1'b1;
        repeat (60) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_cs",    32'(flash_cs),  32'd1);
        check_eq("mid_rst_sck",   32'(flash_clk), 32'd0);
        check_eq("mid_rst_ready", 32'(ready),     32'd1);
        check_eq("mid_rst_data",  data_out,       32'h0);
        @(negedge clk);
        flash_enable = 1'b0; read_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        push_read(24'h000104);
        exp_data.push_back(32'h8877_6655);
        run_op(1'b1, 1'b0, 24'h000104, 32'h0, 0, lat);

        // Sector-aligned write.
`ifdef FLASH_ERASE_EN
        push_b(8'h06); push_b(8'h20); push_addr(24'h001000); push_polls(1);
`endif
        push_prog(24'h001000, 32'h1122_3344, 1);
        exp_data.push_back(32'h8877_6655);
        run_op(1'b0, 1'b1, 24'h001000, 32'h1122_3344, 0, lat);

        // Not sector-aligned: never erases.
        push_prog(24'h001004, 32'h5566_7788, 1);
        exp_data.push_back(32'h8877_6655);
        run_op(1'b0, 1'b1, 24'h001004, 32'h5566_7788, 0, lat);

`ifdef FLASH_ERASE_EN
        // Erase poll timeout abandons the write before programming.
        push_b(8'h06); push_b(8'h20); push_addr(24'h002000); push_polls(POLL_LIMIT);
        exp_data.push_back(32'hDEAD_0002);
        run_op(1'b0, 1'b1, 24'h002000, 32'h99AA_BBCC, 100, lat);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
